seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller for a bank of common-anode 7-segment digits sharing one hex-to-segment decoder. Holds a display word, walks a one-hot active-low anode strobe across the digits at a programmable refresh rate with a dead-time gap between digits, and presents the active digit's nibble to the shared decoder. New values are accepted through a load/ack handshake and applied only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- DIGITS, 4: number of digits; valid range 2..8.
- REFRESH_DIV, 50000: clock cycles each digit is lit (SHOW); ≥1.
- GAP_CYCLES, 2: all-anodes-off cycles between digits (GAP); ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; low freezes counters and blanks anodes.
- load  in  1  single-cycle strobe; samples value.
- value  in  4*DIGITS  display word; nibble i drives digit i (digit 0 = least significant).
- upd_ack  out  1  one-cycle pulse when a loaded value becomes visible.
- digit_bin  out  4  nibble of the selected digit, to the shared decoder.
- digit_sel  out  clog2(DIGITS)  index of the selected digit.
- an  out  DIGITS  anode strobes, active-low, one-hot-low or all-high.

## Operation
- Registers: shadow (displayed word), pend_val/pend_flag, state {SHOW, GAP}, prescaler, gap counter, digit_sel.
- Reset: state=GAP, gap counter=0, prescaler=0, digit_sel=0, shadow=0, pend_flag=0, an=all 1, digit_bin=0, upd_ack=0.
- GAP: an=all 1; after GAP_CYCLES cycles go to SHOW; an drives low only bit digit_sel.
- SHOW: lasts REFRESH_DIV cycles; on its last cycle → GAP and digit_sel increments, wrapping DIGITS-1→0.
- digit_bin = shadow nibble at digit_sel, registered; updates on GAP entry so the decoder settles before the anode turns on.
- Frame boundary = the edge where digit_sel wraps to 0. If pend_flag is set there: shadow←pend_val, pend_flag←0, upd_ack=1 next cycle.
- load: pend_val←value, pend_flag←1. Load while pending overwrites pend_val (last wins; one ack).
- load in the same cycle as a boundary: shadow takes the previous pend_val if any; the new value stays pending for the next boundary. With no prior pending value, the new value waits a full frame.
- en=0: prescaler, gap counter, digit_sel and state hold; an=all 1 next cycle; loads still captured, no shadow update. en→1 resumes mid-slot where it stopped.
- rst mid-frame discards the pending value; no ack is issued.

## Timing
- Frame period = DIGITS*(REFRESH_DIV+GAP_CYCLES) cycles.
- First anode low at cycle GAP_CYCLES after rst deasserts.
- an, digit_bin, digit_sel, upd_ack all registered; no combinational path from inputs to outputs.
- Load-to-visible latency: up to one frame plus 1 cycle; ack aligns with the first GAP of digit 0 in the new frame.
- Never two anodes low; an changes only at SHOW/GAP transitions.

## Configuration
- SEG_SCAN_LZB_EN defined: leading-zero blanking. Digit i>0 is blanked when nibble i and all higher nibbles of shadow are 0; in its SHOW slot an stays all 1, with slot timing unchanged. Digit 0 is never blanked.
- Undefined: every digit lights in its slot.

## Test plan
- DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=2, after rst: an=1111 for 2 cycles, then 1110 for 4, 1111 for 2, 1101 for 4 …; frame repeats every 24 cycles.
- load value=16'h1234 mid-frame → digits unchanged until wrap; upd_ack 1 cycle; then digit_bin 4,3,2,1 in slots 0..3.
- load 16'hAAAA then 16'h5555 before the boundary → single ack; display shows 5555 only.
- load 16'h00F0 at the exact boundary cycle, with pending 16'h1111 → 1111 shown this frame, 00F0 the next, one ack each.
- en low for 10 cycles in digit 2's SHOW → an=1111, digit_sel=2 held; resumes with remaining SHOW cycles.
- SEG_SCAN_LZB_EN, value=16'h0007 → only digit 0 anode pulses; value=16'h0000 → digit 0 still shows 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment anode scanner with frame-aligned display updates.
// Optional build macro SEG_SCAN_LZB_EN enables leading-zero blanking of digits above digit 0.
module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       value,
  output logic                      upd_ack,
  output logic [3:0]                digit_bin,
  output logic [$clog2(DIGITS)-1:0] digit_sel,
  output logic [DIGITS-1:0]         an
);

  localparam int SW = $clog2(DIGITS);
  localparam int PW = $clog2(REFRESH_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [SW-1:0] LAST_DIG = SW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [0:0] {GAP = 1'b0, SHOW = 1'b1} state_t;

  state_t              state_r;
  logic [PW-1:0]       presc_r;
  logic [GW-1:0]       gap_cnt_r;
  logic [4*DIGITS-1:0] shadow_r;
  logic [4*DIGITS-1:0] pend_val_r;
  logic                pend_flag_r;

  logic                wrap_s;
  logic [SW-1:0]       next_sel_s;
  logic [4*DIGITS-1:0] next_word_s;
  logic [DIGITS-1:0]   blank_s;
  logic [DIGITS-1:0]   strobe_s;

  // Next digit index and the word it will be decoded from (pending word wins at the frame wrap).
  always_comb begin
    wrap_s      = (digit_sel == LAST_DIG);
    next_sel_s  = wrap_s ? {SW{1'b0}} : (digit_sel + SW'(1));
    next_word_s = (wrap_s && pend_flag_r) ? pend_val_r : shadow_r;
  end

  // Per-digit blanking mask; digit 0 always lights.
  always_comb begin
    blank_s = {DIGITS{1'b0}};
`ifdef SEG_SCAN_LZB_EN
    for (int i = 1; i < DIGITS; i++) begin
      blank_s[i] = ((shadow_r >> (4 * i)) == {(4*DIGITS){1'b0}});
    end
`endif
  end

  // Active-low strobe for the selected digit, suppressed when that digit is blanked.
  always_comb begin
    strobe_s            = {DIGITS{1'b1}};
    strobe_s[digit_sel] = blank_s[digit_sel];
  end

  // Scan state machine, display shadow and pending-load handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= GAP;
      presc_r     <= {PW{1'b0}};
      gap_cnt_r   <= {GW{1'b0}};
      digit_sel   <= {SW{1'b0}};
      shadow_r    <= {(4*DIGITS){1'b0}};
      pend_val_r  <= {(4*DIGITS){1'b0}};
      pend_flag_r <= 1'b0;
      an          <= {DIGITS{1'b1}};
      digit_bin   <= 4'h0;
      upd_ack     <= 1'b0;
    end else begin
      upd_ack <= 1'b0;
      if (load) begin
        pend_val_r  <= value;
        pend_flag_r <= 1'b1;
      end
      if (!en) begin
        an <= {DIGITS{1'b1}};
      end else begin
        case (state_r)
          GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
              gap_cnt_r <= {GW{1'b0}};
              state_r   <= SHOW;
              an        <= strobe_s;
            end else begin
              gap_cnt_r <= gap_cnt_r + GW'(1);
              an        <= {DIGITS{1'b1}};
            end
          end
          SHOW: begin
            if (presc_r == PRE_LAST) begin
              presc_r   <= {PW{1'b0}};
              state_r   <= GAP;
              an        <= {DIGITS{1'b1}};
              digit_sel <= next_sel_s;
              // Decoder input changes at GAP entry so it settles before the anode turns on.
              digit_bin <= next_word_s[{next_sel_s, 2'b00} +: 4];
              if (wrap_s && pend_flag_r) begin
                shadow_r    <= pend_val_r;
                pend_flag_r <= load;
                upd_ack     <= 1'b1;
              end
            end else begin
              presc_r <= presc_r + PW'(1);
              an      <= strobe_s;
            end
          end
          default: begin
            state_r <= GAP;
            an      <= {DIGITS{1'b1}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: table vectors, directed frame sequences, and randomized
// stimulus checked against a position-in-frame reference model.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int RD     = 4;
  localparam int G      = 2;
  localparam int L      = RD + G;
  localparam int F      = DIGITS * L;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        upd_ack;
  logic [3:0]  digit_bin;
  logic [1:0]  digit_sel;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: enabled-cycle position within the frame, committed and pending words.
  int          m_pos = 0;
  logic [15:0] m_shadow = 16'h0;
  logic [15:0] m_pend = 16'h0;
  bit          m_flag = 1'b0;
  bit          m_ack = 1'b0;
  bit          m_frozen = 1'b0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .upd_ack(upd_ack), .digit_bin(digit_bin), .digit_sel(digit_sel), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, e, l;
    logic [15:0] v;
    logic [3:0]  an;
    logic [1:0]  sel;
    logic [3:0]  bin;
    logic        ack;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit blanked(input int s, input logic [15:0] w);
    return LZB && (s != 0) && ((w >> (4 * s)) == 16'h0);
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare all outputs 1 time unit later.
  task automatic step(input logic r, input logic e, input logic l, input logic [15:0] v);
    bit          old_flag;
    logic [15:0] old_pend;
    int          s, o;
    logic [3:0]  ea;
    rst = r; en = e; load = l; value = v;
    @(posedge clk);
    if (r) begin
      m_pos = 0; m_shadow = 16'h0; m_flag = 1'b0; m_ack = 1'b0; m_frozen = 1'b0;
    end else begin
      old_flag = m_flag;
      old_pend = m_pend;
      m_ack    = 1'b0;
      if (l) begin
        m_pend = v;
        m_flag = 1'b1;
      end
      m_frozen = !e;
      if (e) begin
        m_pos = (m_pos + 1) % F;
        if (m_pos == 0 && old_flag) begin
          m_shadow = old_pend;
          m_ack    = 1'b1;
          if (!l) m_flag = 1'b0;
        end
      end
    end
    #1;
    s  = m_pos / L;
    o  = m_pos % L;
    ea = 4'hF;
    if (!(m_frozen || o < G || blanked(s, m_shadow))) ea = ~(4'b0001 << s);
    check("an", {28'h0, an}, {28'h0, ea});
    check("digit_sel", {30'h0, digit_sel}, s);
    check("digit_bin", {28'h0, digit_bin}, (m_shadow >> (4 * s)) & 16'hF);
    check("upd_ack", {31'h0, upd_ack}, {31'h0, m_ack});
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 2 * F && !got; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      if (upd_ack) got = 1'b1;
    end
  endtask

  // Runs the remaining F-1 cycles of a frame that started on the previous cycle.
  task automatic run_frame(output logic [15:0] shown, output int acks, output logic [3:0] lit);
    shown = 16'h0; acks = 0; lit = 4'h0;
    for (int i = 0; i < F - 1; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      shown[{digit_sel, 2'b00} +: 4] = digit_bin;
      acks += int'(upd_ack);
      lit |= ~an;
    end
  endtask

  initial begin
    bit          got;
    int          acks;
    int          lit_cnt;
    logic [15:0] shown;
    logic [3:0]  lit;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0, 4'hF, 2'd0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0, 4'hF, 2'd0, 4'h0, 1'b0};
    for (int i = 2; i < 6; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 16'h0, 4'hE, 2'd0, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0, 4'hF, 2'd1, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0, 4'hF, 2'd1, 4'h0, 1'b0};
    for (int i = 8; i < 12; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 16'h0, 4'hD, 2'd1, 4'h0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0, 4'hF, 2'd2, 4'h0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 16'h0, 4'hF, 2'd2, 4'h0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 16'h0, 4'hB, 2'd2, 4'h0, 1'b0};

    step(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].v);
      check("tbl_an", {28'h0, an}, {28'h0, tbl[i].an});
      check("tbl_sel", {30'h0, digit_sel}, {30'h0, tbl[i].sel});
      check("tbl_bin", {28'h0, digit_bin}, {28'h0, tbl[i].bin});
      check("tbl_ack", {31'h0, upd_ack}, {31'h0, tbl[i].ack});
    end

    // Mid-frame load becomes visible only after the wrap.
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    wait_ack(got);
    check("ack_1234", {31'h0, got}, 32'h1);
    run_frame(shown, acks, lit);
    check("shown_1234", {16'h0, shown}, 32'h1234);
    check("acks_1234", acks, 0);

    // Load at a boundary with nothing pending waits a frame; a later load overwrites it.
    step(1'b0, 1'b1, 1'b1, 16'hAAAA);
    check("no_ack_empty_boundary", {31'h0, upd_ack}, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h5555);
    wait_ack(got);
    check("ack_5555", {31'h0, got}, 32'h1);
    run_frame(shown, acks, lit);
    check("shown_5555", {16'h0, shown}, 32'h5555);
    check("acks_5555", acks, 0);

    // Pending 1111 commits at the boundary where 00F0 is loaded; 00F0 follows a frame later.
    step(1'b0, 1'b1, 1'b1, 16'h1111);
    check("no_ack_1111_load", {31'h0, upd_ack}, 32'h0);
    run_frame(shown, acks, lit);
    check("shown_still_5555", {16'h0, shown}, 32'h5555);
    step(1'b0, 1'b1, 1'b1, 16'h00F0);
    check("ack_1111", {31'h0, upd_ack}, 32'h1);
    run_frame(shown, acks, lit);
    check("shown_1111", {16'h0, shown}, 32'h1111);
    check("acks_1111", acks, 0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("ack_00f0", {31'h0, upd_ack}, 32'h1);
    run_frame(shown, acks, lit);
    check("shown_00f0", {16'h0, shown}, 32'h00F0);
    check("acks_00f0", acks, 0);

    // Freeze in the middle of digit 2's SHOW slot, then resume.
    for (int i = 0; i < 2 * F && m_pos != 15; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    check("pre_freeze_an", {28'h0, an}, 32'hB);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("freeze_an", {28'h0, an}, 32'hF);
      check("freeze_sel", {30'h0, digit_sel}, 32'h2);
    end
    lit_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      if (an == 4'hF) break;
      lit_cnt++;
    end
    check("resume_lit_cycles", lit_cnt, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 11) == 0), 16'($urandom));
    end

    // Blanking behaviour (all digits light when the feature is not built in).
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0007);
    wait_ack(got);
    check("ack_0007", {31'h0, got}, 32'h1);
    run_frame(shown, acks, lit);
    check("shown_0007", {16'h0, shown}, 32'h0007);
    check("lit_0007", {28'h0, lit}, LZB ? 32'h1 : 32'hF);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    wait_ack(got);
    check("ack_0000", {31'h0, got}, 32'h1);
    run_frame(shown, acks, lit);
    check("shown_0000", {16'h0, shown}, 32'h0);
    check("lit_0000", {28'h0, lit}, LZB ? 32'h1 : 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
